// File: rtl/floor_request_writer.sv
// Write-side producer for the elevator request FIFO: synchronises call buttons,
// drops duplicate calls, round-robin arbitrates waiting floors and drives lamps.
module floor_request_writer #(
  parameter int NUM_FLOORS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic                  fifo_full,
  output logic                  fifo_wr,
  output logic [3:0]            fifo_din,
  input  logic                  fifo_rd_mon,
  input  logic [3:0]            fifo_dout_mon,
  output logic [NUM_FLOORS-1:0] req_lamp,
  output logic                  dbg_state_o
);

  // FIFO write handshake: fifo_wr is a single-cycle strobe, only raised from
  // S_ARB when fifo_full was low; fifo_din is meaningful only while fifo_wr=1.
  typedef enum logic {
    S_ARB = 1'b0,
    S_GAP = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] queued_q, queued_d;
  logic [3:0]            last_grant_q, last_grant_d;
  logic                  fifo_wr_q, fifo_wr_d;
  logic [3:0]            fifo_din_q, fifo_din_d;

  logic [NUM_FLOORS-1:0]   rise, clr, grant, rot;
  logic [2*NUM_FLOORS-1:0] dbl;
  logic [4:0]              shamt;
  logic [3:0]              winner;
  logic                    found, take;

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    clr = '0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      clr[k] = fifo_rd_mon && (fifo_dout_mon == 4'(k));
    end
  end

  // Rotate pending so bit 0 is the floor just after the last grant.
  always_comb begin
    dbl    = {pending_q, pending_q};
    shamt  = {1'b0, last_grant_q} + 5'd1;
    rot    = NUM_FLOORS'(dbl >> shamt);
    found  = 1'b0;
    winner = last_grant_q;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (!found && rot[i]) begin
        found  = 1'b1;
        winner = 4'((int'(last_grant_q) + 1 + i) % NUM_FLOORS);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    fifo_wr_d    = 1'b0;
    fifo_din_d   = fifo_din_q;
    last_grant_d = last_grant_q;
    take         = 1'b0;
    grant        = '0;
    case (state_q)
      S_ARB: begin
        if (found && !fifo_full) begin
          take         = 1'b1;
          grant        = NUM_FLOORS'(1) << winner;
          fifo_wr_d    = 1'b1;
          fifo_din_d   = winner;
          last_grant_d = winner;
          state_d      = S_GAP;
        end
      end
      S_GAP: begin
        // Lets the FIFO's registered full flag catch up before the next write.
        state_d = S_ARB;
      end
      default: state_d = S_ARB;
    endcase
  end

  // A press for a floor still queued is absorbed, unless it is read this cycle.
  always_comb begin
    queued_d  = (queued_q & ~clr) | grant;
    pending_d = (pending_q | (rise & ~(queued_q & ~clr))) & ~grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_ARB;
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      pending_q    <= '0;
      queued_q     <= '0;
      last_grant_q <= 4'(NUM_FLOORS - 1);
      fifo_wr_q    <= 1'b0;
      fifo_din_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      pending_q    <= pending_d;
      queued_q     <= queued_d;
      last_grant_q <= last_grant_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_din_q   <= fifo_din_d;
    end
  end

  assign fifo_wr     = fifo_wr_q;
  assign fifo_din    = fifo_din_q;
  assign req_lamp    = pending_q | queued_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_floor_request_writer.sv
// Directed bench for floor_request_writer: latency, duplicate suppression,
// round-robin order, backpressure, clear/press collision and async reset.
module tb_floor_request_writer;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic         fifo_full;
  logic         fifo_wr;
  logic [3:0]   fifo_din;
  logic         fifo_rd_mon;
  logic [3:0]   fifo_dout_mon;
  logic [N-1:0] req_lamp;
  logic         dbg_state;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];
  logic [3:0] wr_q[$];

  floor_request_writer #(.NUM_FLOORS(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn           (btn),
    .fifo_full     (fifo_full),
    .fifo_wr       (fifo_wr),
    .fifo_din      (fifo_din),
    .fifo_rd_mon   (fifo_rd_mon),
    .fifo_dout_mon (fifo_dout_mon),
    .req_lamp      (req_lamp),
    .dbg_state_o   (dbg_state)
  );

  // Clock / write monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr) wr_q.push_back(fifo_din);
  end

  // Driver tasks
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    btn           = '0;
    fifo_full     = 1'b0;
    fifo_rd_mon   = 1'b0;
    fifo_dout_mon = 4'd0;
    step(2);
    rst = 1'b0;
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic read_floor(input logic [3:0] f);
    fifo_rd_mon   = 1'b1;
    fifo_dout_mon = f;
    step();
    fifo_rd_mon   = 1'b0;
  endtask

  task automatic wait_wr(input string tag, input int budget);
    int n;
    n = 0;
    while (!fifo_wr && n < budget) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 32'(fifo_wr), 32'd1);
  endtask

  // Scoreboard: compare collected writes against the expected queue
  task automatic check_writes(input string tag);
    check({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      check({tag, "_floor"}, 32'(wr_q.pop_front()), 32'(exp_q.pop_front()));
    end
    wr_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    btn = '0; fifo_full = 1'b0; fifo_rd_mon = 1'b0; fifo_dout_mon = 4'd0;
    #2;
    check("rst_wr", 32'(fifo_wr), 32'd0);
    check("rst_din", 32'(fifo_din), 32'd0);
    check("rst_lamp", 32'(req_lamp), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    do_reset();

    // Single press: lamp at edge 2, write at edge 3, exactly once
    btn[5] = 1'b1;
    step(2);
    check("sp_lamp_e1", 32'(req_lamp[5]), 32'd0);
    step();
    check("sp_lamp_e2", 32'(req_lamp), 32'h0020);
    check("sp_wr_e2", 32'(fifo_wr), 32'd0);
    step();
    check("sp_wr_e3", 32'(fifo_wr), 32'd1);
    check("sp_din_e3", 32'(fifo_din), 32'd5);
    check("sp_state_e3", 32'(dbg_state), 32'd1);
    step();
    check("sp_wr_e4", 32'(fifo_wr), 32'd0);
    step(10);
    exp_q.push_back(4'd5);
    check_writes("sp");
    read_floor(4'd5);
    check("sp_lamp_clr", 32'(req_lamp), 32'd0);

    // Duplicate suppression, then re-request after the read
    do_reset();
    btn[3] = 1'b1; step(6);
    btn[3] = 1'b0; step(3);
    btn[3] = 1'b1; step(6);
    btn[3] = 1'b0; step(3);
    exp_q.push_back(4'd3);
    check_writes("dup");
    check("dup_lamp_on", 32'(req_lamp[3]), 32'd1);
    read_floor(4'd3);
    check("dup_lamp_off", 32'(req_lamp[3]), 32'd0);
    btn[3] = 1'b1; step(3);
    check("dup_lamp_again", 32'(req_lamp[3]), 32'd1);
    step(4);
    btn[3] = 1'b0;
    exp_q.push_back(4'd3);
    check_writes("dup2");

    // Round-robin with wrap-around
    do_reset();
    btn[2] = 1'b1; btn[7] = 1'b1; btn[12] = 1'b1;
    step(4);
    check("rr_w0", 32'({fifo_wr, fifo_din}), 32'h12);
    step();
    check("rr_gap", 32'(fifo_wr), 32'd0);
    step();
    check("rr_w1", 32'({fifo_wr, fifo_din}), 32'h17);
    step(2);
    check("rr_w2", 32'({fifo_wr, fifo_din}), 32'h1c);
    btn = '0; btn[1] = 1'b1; btn[9] = 1'b1;
    step(12);
    btn = '0; btn[3] = 1'b1; btn[11] = 1'b1;
    step(12);
    btn = '0;
    exp_q.push_back(4'd2);  exp_q.push_back(4'd7); exp_q.push_back(4'd12);
    exp_q.push_back(4'd1);  exp_q.push_back(4'd9);
    exp_q.push_back(4'd11); exp_q.push_back(4'd3);
    check_writes("rr");

    // Full backpressure
    do_reset();
    fifo_full = 1'b1;
    btn[4] = 1'b1; btn[6] = 1'b1;
    step(8);
    check("full_nowr", 32'(wr_q.size()), 32'd0);
    check("full_lamps", 32'(req_lamp), 32'h0050);
    fifo_full = 1'b0;
    wait_wr("full_w0", 10);
    check("full_din0", 32'(fifo_din), 32'd4);
    step();
    check("full_gap", 32'(fifo_wr), 32'd0);
    step();
    check("full_w1", 32'({fifo_wr, fifo_din}), 32'h16);
    btn = '0;

    // Clear/press collision on floor 8
    do_reset();
    btn[8] = 1'b1; step(6);
    btn[8] = 1'b0; step(4);
    btn[8] = 1'b1;
    step(2);
    read_floor(4'd8);
    check("col_lamp", 32'(req_lamp[8]), 32'd1);
    step(4);
    btn[8] = 1'b0;
    exp_q.push_back(4'd8); exp_q.push_back(4'd8);
    check_writes("col");

    // Async reset mid-operation
    do_reset();
    btn[1] = 1'b1; btn[2] = 1'b1; btn[3] = 1'b1;
    step(4);
    check("ar_wr_before", 32'(fifo_wr), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_wr", 32'(fifo_wr), 32'd0);
    check("ar_din", 32'(fifo_din), 32'd0);
    check("ar_lamp", 32'(req_lamp), 32'd0);
    btn = '0;
    step(2);
    rst = 1'b0;
    wr_q.delete();
    btn[0] = 1'b1;
    wait_wr("ar_w0", 10);
    check("ar_din0", 32'(fifo_din), 32'd0);
    step(6);
    btn = '0;
    exp_q.push_back(4'd0);
    check_writes("ar");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/floor_request_writer.md
Name: floor_request_writer

Overview:
- Write-side producer for the elevator request FIFO.
- Captures raw call-button presses, one button per floor, and synchronises and edge-detects them.
- Drops duplicate presses for floors already waiting or queued.
- Arbitrates round-robin among waiting floors and pushes 4-bit floor numbers into the FIFO that the elevator controller drains.
- Snoops the FIFO read port to learn when a queued floor has been taken into service, and drives per-floor call lamps.

Parameters:
- NUM_FLOORS, 16, number of floors/buttons; legal range 2..16; floor numbers are 0..NUM_FLOORS-1 on the 4-bit bus.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- btn  in  NUM_FLOORS  raw call buttons, level, asynchronous to clk, 1 = pressed
- fifo_full  in  1  request FIFO full; no write may be issued while high
- fifo_wr  out  1  one-cycle write strobe into the FIFO
- fifo_din  out  4  floor number written; valid when fifo_wr=1
- fifo_rd_mon  in  1  copy of the FIFO read strobe issued by the elevator controller
- fifo_dout_mon  in  4  copy of FIFO read data; sampled when fifo_rd_mon=1
- req_lamp  out  NUM_FLOORS  call lamp per floor = pending | queued

Behaviour:
- Reset (async, rst=1):
  - fifo_wr=0, fifo_din=0, req_lamp=0.
  - All synchroniser, edge-detect, pending and queued registers = 0.
  - last_grant = NUM_FLOORS-1; state = S_ARB.
  - Reset mid-operation discards all pending/queued state. Entries already in the FIFO are not recalled.
- Input path, per bit:
  - Two-flop synchroniser sync1 -> sync2, then register prev.
  - rise[k] = sync2[k] & ~prev[k].
  - Held buttons produce a single rise; release and re-press is needed for another.
- Pending/queued update, every cycle:
  - clr[k] = fifo_rd_mon & (fifo_dout_mon == k); values >= NUM_FLOORS are ignored.
  - queued[k] next = (queued[k] & ~clr[k]) | grant_set[k].
  - pending[k] next = (pending[k] | (rise[k] & ~(queued[k] & ~clr[k]))) & ~grant_clr[k].
  - Press on a floor already pending: no effect.
  - Press on a floor queued and not being cleared this cycle: ignored.
  - Press in the same cycle its queued bit clears: sets pending, so a new request is queued.
  - Press on floor k in the same cycle k is granted: absorbed, because k is now queued.
- FSM:
  - S_ARB:
    - If (|pending) & ~fifo_full: choose the winner w, searching pending from (last_grant+1) mod NUM_FLOORS upward with wrap-around.
    - Register fifo_wr<=1, fifo_din<=w, last_grant<=w, grant_set[w], grant_clr[w]; go to S_GAP.
    - Otherwise fifo_wr<=0 and stay.
  - S_GAP: fifo_wr<=0; go to S_ARB. This one-cycle gap lets the FIFO's registered full flag update.
  - Max throughput: 1 write per 2 cycles.
- fifo_full:
  - Evaluated only in S_ARB, registered before the write.
  - Pending requests wait indefinitely while full; nothing is lost or dropped.
  - Lamps stay lit while waiting.
- Latency:
  - btn[k] rising before edge 0 gives sync1 at edge 0, sync2 at edge 1, and pending/lamp at edge 2.
  - fifo_wr=1 with fifo_din=k at edge 3 (FIFO not full, FSM in S_ARB, k wins).
- req_lamp is decoded directly from registers; it is not combinational from inputs.
- Lamp k extinguishes the cycle after the elevator reads floor k.
- Width rules:
  - fifo_din is zero-extended from the winner index.
  - last_grant wrap: NUM_FLOORS-1 -> 0.
  - Unused btn bits do not exist; the port width is NUM_FLOORS.

Test Plan:
- Single press: btn[5] high from cycle 0, fifo_full=0 -> req_lamp[5]=1 at edge 2; fifo_wr=1, fifo_din=5 at edge 3 for exactly one cycle; no further writes while btn[5] stays high.
- Duplicate suppression: press floor 3, release, press again before any read -> exactly one write of 3; fifo_rd_mon=1 with fifo_dout_mon=3, then press again -> a second write of 3; lamp[3] drops for one cycle between.
- Round-robin: after reset, press 2, 7 and 12 in the same cycle -> writes 2, 7, 12 on alternate cycles; then press 1 and 9 with last_grant=12 -> order 1, 9 (wrap-around).
- Full backpressure: fifo_full=1, press 4 and 6 -> no fifo_wr, lamps 4 and 6 lit; deassert full -> writes 4 then 6, two cycles apart.
- Clear/press collision: floor 8 queued; in one cycle fifo_rd_mon=1, fifo_dout_mon=8 and rise[8]=1 -> pending[8] set, and 8 is written again.
- Async reset mid-operation: floors 1, 2 and 3 pending and fifo_wr=1, assert rst -> fifo_wr=0, fifo_din=0, req_lamp=0 immediately; after release, the next press of 0 -> first write is 0.
